// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin arbiter sharing one pipelined signed Q1.(BITSIZE-1)
// multiplier among NREQ requesters. Result strobes return to the issuing requester.
// Optional build macro MULT_SCHEDULER_SAT_EN: saturate the min*min overflow case
// to the maximum positive value instead of returning the raw wrapped slice.
module mult_scheduler #(
   parameter int BITSIZE = 16,
   parameter int NREQ    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*BITSIZE-1:0]   req_a,
   input  logic [NREQ*BITSIZE-1:0]   req_b,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           res_valid,
   output logic [BITSIZE-1:0]        res_data,
   output logic                      res_ovf,
   output logic                      busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = 2 * BITSIZE;

   // Takes the top BITSIZE+1 product bits; returns {ovf, data}. The two top
   // bits differ only for min*min, the single product outside the Q1 range.
   function automatic logic [BITSIZE:0] renorm_sat(input logic [BITSIZE:0] top);
      logic                ovf;
      logic [BITSIZE-1:0]  data;
      ovf  = top[BITSIZE] ^ top[BITSIZE-1];
      data = top[BITSIZE-1:0];
`ifdef MULT_SCHEDULER_SAT_EN
      if (ovf) data = {1'b0, {(BITSIZE-1){1'b1}}};
`endif
      return {ovf, data};
   endfunction

   logic [IW-1:0]               ptr;
   logic [IW-1:0]               gnt_idx;
   logic                        gnt_any;
   logic                        xfer;

   logic signed [BITSIZE-1:0]   a_p0;
   logic signed [BITSIZE-1:0]   b_p0;
   logic [IW-1:0]               idx_p0;
   logic                        vld_p0;

   logic signed [PW-1:0]        prod_p1;
   logic [IW-1:0]               idx_p1;
   logic                        vld_p1;

   logic [NREQ-1:0]             vld_p2;
   logic [BITSIZE-1:0]          data_p2;
   logic                        ovf_p2;

   logic [NREQ-1:0]             vld_dec;
   logic [BITSIZE:0]            rn;
   logic                        unused_prod_lsb;

   // Round-robin search: start at the pointer, scan upward with wrap, first valid wins.
   always_comb begin
      int cand;
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr) + off) % NREQ;
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(cand);
         end
      end
   end

   assign xfer = gnt_any && !rst;

   // One-hot grant, forced to zero during reset.
   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[gnt_idx] = 1'b1;
   end

   // Decode the stage-2 requester index into the one-hot result strobe.
   always_comb begin
      vld_dec = '0;
      if (vld_p1) vld_dec[idx_p1] = 1'b1;
   end

   assign rn              = renorm_sat(prod_p1[PW-1 -: BITSIZE+1]);
   assign unused_prod_lsb = ^prod_p1[BITSIZE-2:0];

   // Stage p0 (transfer edge): capture the granted operand pair and its index.
   always_ff @(posedge clk) begin
      a_p0   <= $signed(req_a[gnt_idx*BITSIZE +: BITSIZE]);
      b_p0   <= $signed(req_b[gnt_idx*BITSIZE +: BITSIZE]);
      idx_p0 <= gnt_idx;
   end

   // Stage p1: full-width signed product.
   always_ff @(posedge clk) begin
      prod_p1 <= PW'(a_p0) * PW'(b_p0);
      idx_p1  <= idx_p0;
   end

   // Control state: pointer, valid flags and the registered outputs, all cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         vld_p2  <= '0;
         data_p2 <= '0;
         ovf_p2  <= 1'b0;
      end else begin
         if (xfer)
            ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         vld_p0 <= xfer;
         vld_p1 <= vld_p0;
         // Stage p2: output register; data holds between strobes.
         vld_p2 <= vld_dec;
         ovf_p2 <= vld_p1 & rn[BITSIZE];
         if (vld_p1) data_p2 <= rn[BITSIZE-1:0];
      end
   end

   assign res_valid = rst ? '0 : vld_p2;
   assign res_data  = rst ? '0 : data_p2;
   assign res_ovf   = !rst && ovf_p2;
   assign busy      = !rst && (vld_p0 || vld_p1 || (|vld_p2));

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler (BITSIZE=16, NREQ=4): the driver pushes the
// hand-computed result of every granted transfer, the monitor pops on each result strobe.
module tb_mult_scheduler;

   localparam int B = 16;
   localparam int N = 4;
`ifdef MULT_SCHEDULER_SAT_EN
   localparam logic [B-1:0] OVF_DATA = 16'h7FFF;
`else
   localparam logic [B-1:0] OVF_DATA = 16'h8000;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*B-1:0] req_a = '0;
   logic [N*B-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   res_valid;
   logic [B-1:0]   res_data;
   logic           res_ovf;
   logic           busy;

   mult_scheduler #(.BITSIZE(B), .NREQ(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
      .res_ovf(res_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           idx;
      logic [B-1:0] data;
      logic         ovf;
      int           edge_n;
   } exp_t;

   exp_t         q[$];
   logic [B-1:0] exp_d [N];
   logic         exp_o [N];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [B-1:0] last_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_ops(input int i, input logic [B-1:0] a, input logic [B-1:0] b,
                          input logic [B-1:0] d, input logic o);
      req_a[i*B +: B] = a;
      req_b[i*B +: B] = b;
      exp_d[i] = d;
      exp_o[i] = o;
   endtask

   // One cycle of stimulus: drive req_valid, check the grant, queue the expected result.
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] er);
      exp_t e;
      @(negedge clk);
      #1;
      req_valid = v;
      #1;
      chk("req_ready", 32'(req_ready), 32'(er));
      for (int i = 0; i < N; i++) begin
         if (er[i]) begin
            e.idx    = i;
            e.data   = exp_d[i];
            e.ovf    = exp_o[i];
            e.edge_n = cyc + 1;
            q.push_back(e);
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      @(negedge clk);
      #3;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("res_valid_idle", 32'(res_valid), 32'd0);
      chk("res_data_hold", 32'(res_data), 32'(last_data));
   endtask

   // Monitor: every result strobe must match the oldest outstanding transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (res_valid !== '0) begin
            if (q.size() == 0) begin
               chk("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
               e = q.pop_front();
               chk("res_valid", 32'(res_valid), 32'(1) << e.idx);
               chk("res_data", 32'(res_data), 32'(e.data));
               chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
               chk("latency", 32'(cyc), 32'(e.edge_n + 2));
               last_data = e.data;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with every requester asking: no grants, outputs quiet.
      req_valid = 4'b1111;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_ovf", 32'(res_ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      req_valid = '0;

      // Single request from requester 2: 0.5 * 0.25 = 0.125.
      set_ops(2, 16'h4000, 16'h2000, 16'h1000, 1'b0);
      step(4'b0100, 4'b0100);
      step(4'b0000, 4'b0000);
      chk("busy_active", 32'(busy), 32'd1);
      drain();

      // Pointer at 3: requester 0 wins after wrap. -0.5 * 0.5 = -0.25.
      set_ops(0, 16'hC000, 16'h4000, 16'hE000, 1'b0);
      step(4'b0001, 4'b0001);
      step(4'b0000, 4'b0000);
      drain();

      // -1.0 * -1.0 overflow.
      set_ops(0, 16'h8000, 16'h8000, OVF_DATA, 1'b1);
      step(4'b0001, 4'b0001);
      step(4'b0000, 4'b0000);
      drain();

      // Move pointer to 2 via requester 1, then 1 and 3 both valid: 3 first, then 1.
      set_ops(1, 16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0);
      set_ops(3, 16'h8000, 16'h7FFF, 16'h8001, 1'b0);
      step(4'b0010, 4'b0010);
      step(4'b1010, 4'b1000);
      step(4'b1010, 4'b0010);
      step(4'b0000, 4'b0000);
      drain();

      // Pointer at 2: 0 granted, requester 1 withdraws before its turn.
      set_ops(0, 16'h2000, 16'h2000, 16'h0800, 1'b0);
      step(4'b0011, 4'b0001);
      step(4'b0000, 4'b0000);
      drain();

      // Two back-to-back transfers, then reset discards them.
      set_ops(2, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
      step(4'b0110, 4'b0010);
      step(4'b0110, 4'b0100);
      @(negedge clk);
      #1;
      rst = 1'b1;
      req_valid = '0;
      q.delete();
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      chk("postrst_res_data", 32'(res_data), 32'd0);
      last_data = '0;
      repeat (4) @(negedge clk);
      #3;
      chk("postrst_busy", 32'(busy), 32'd0);

      // All four continuously valid from pointer 0: grants 0,1,2,3,0,1,2,3.
      set_ops(0, 16'hC000, 16'h4000, 16'hE000, 1'b0);
      set_ops(1, 16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0);
      set_ops(2, 16'h4000, 16'h2000, 16'h1000, 1'b0);
      set_ops(3, 16'h2000, 16'h2000, 16'h0800, 1'b0);
      for (int i = 0; i < 8; i++) step(4'b1111, 4'(1 << (i % 4)));
      step(4'b0000, 4'b0000);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
